// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera pixel packer
package cam_pkg;

    localparam int CAM_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        ACTIVE = 2'd2
    } cam_pack_state_e;

endpackage

// File: rtl/cam_edge_det.sv
// rtl/cam_edge_det.sv - registered rise/fall detector for a single-bit level
//
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_sig         : level to watch (already registered by the caller)
//   o_rise/o_fall : one-cycle pulses when i_sig differs from its delayed copy
module cam_edge_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/cam_pixel_pack.sv
// rtl/cam_pixel_pack.sv - DVP byte stream to RGB565 pixel packer with frame skip
//
// Ports:
//   cam_clk, cam_rstn          : sensor pixel clock, asynchronous active-low reset
//   cam_vsync/cam_href/cam_data: raw sensor frame sync, line valid, byte
//   pix_data/pix_valid         : packed {hi, lo} pixel and its one-cycle strobe
//   pix_vsync                  : delayed vsync, held 0 until streaming
//   pix_x/pix_y                : column/line of the current pix_data
//   frame_ready                : streaming (start-up frames already discarded)
//   odd_line_err               : sticky, some line ended on an unpaired byte
module cam_pixel_pack
    import cam_pkg::*;
#(
    parameter int SKIP_FRAMES = 10,
    parameter int HW          = 12,
    parameter int VW          = 12
) (
    input  logic                  cam_clk,
    input  logic                  cam_rstn,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [CAM_BYTE_W-1:0] cam_data,
    output logic [15:0]           pix_data,
    output logic                  pix_valid,
    output logic                  pix_vsync,
    output logic [HW-1:0]         pix_x,
    output logic [VW-1:0]         pix_y,
    output logic                  frame_ready,
    output logic                  odd_line_err
);

    localparam int SKW = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);

    logic                  r_vsync;
    logic                  r_href;
    logic [CAM_BYTE_W-1:0] r_data;
    logic [CAM_BYTE_W-1:0] r_hi;

    cam_pack_state_e       r_state;
    cam_pack_state_e       w_state_next;
    logic [SKW-1:0]        r_skip_cnt;
    logic [SKW-1:0]        w_skip_next;

    logic [HW-1:0]         r_x;
    logic [VW-1:0]         r_y;
    logic                  r_phase;
    logic                  r_armed;
    logic                  r_line_pix;

    logic [15:0]           r_pix_data;
    logic                  r_pix_valid;
    logic                  r_pix_vsync;
    logic [HW-1:0]         r_pix_x;
    logic [VW-1:0]         r_pix_y;
    logic                  r_odd_err;

    logic w_vs_rise;
    logic w_vs_fall_unused;
    logic w_href_rise;
    logic w_href_fall;
    logic w_active;
    logic w_line_start;
    logic w_armed;
    logic w_byte;
    logic w_emit;

    cam_edge_det u_vsync_edge (
        .i_clk  (cam_clk),
        .i_rstn (cam_rstn),
        .i_sig  (r_vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall_unused)
    );

    cam_edge_det u_href_edge (
        .i_clk  (cam_clk),
        .i_rstn (cam_rstn),
        .i_sig  (r_href),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    assign w_active     = (r_state == ACTIVE);
    // A line only counts if its href rise is seen while streaming and outside
    // vertical blanking; a line already in flight at ACTIVE entry is skipped.
    assign w_line_start = w_active & w_href_rise & ~r_vsync;
    assign w_armed      = r_armed | w_line_start;
    assign w_byte       = w_armed & r_href & ~r_vsync;
    assign w_emit       = w_byte & r_phase;

    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip_cnt;
        case (r_state)
            IDLE: begin
                if (w_vs_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        w_state_next = ACTIVE;
                    end else begin
                        w_state_next = SKIP;
                        w_skip_next  = SKW'(1);
                    end
                end
            end
            SKIP: begin
                if (w_vs_rise) begin
                    if (r_skip_cnt == SKW'(SKIP_FRAMES)) begin
                        w_state_next = ACTIVE;
                    end else begin
                        w_skip_next = r_skip_cnt + SKW'(1);
                    end
                end
            end
            ACTIVE:  w_state_next = ACTIVE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge cam_clk or negedge cam_rstn) begin
        if (!cam_rstn) begin
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_data      <= '0;
            r_hi        <= '0;
            r_state     <= IDLE;
            r_skip_cnt  <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_phase     <= 1'b0;
            r_armed     <= 1'b0;
            r_line_pix  <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_vsync <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_odd_err   <= 1'b0;
        end else begin
            r_vsync    <= cam_vsync;
            r_href     <= cam_href;
            r_data     <= cam_data;
            r_state    <= w_state_next;
            r_skip_cnt <= w_skip_next;

            // Next-state gating lets pix_vsync start on the same edge that
            // enters ACTIVE, lining up with frame_ready.
            r_pix_vsync <= r_vsync & (w_state_next == ACTIVE);
            r_pix_valid <= w_emit;
            if (w_emit) begin
                r_pix_data <= {r_hi, r_data};
                r_pix_x    <= r_x;
                r_pix_y    <= r_y;
            end

            // Evaluated independently so a coincident vsync rise cannot hide it.
            if (w_href_fall && r_phase) begin
                r_odd_err <= 1'b1;
            end

            if (w_vs_rise) begin
                r_x        <= '0;
                r_y        <= '0;
                r_phase    <= 1'b0;
                r_armed    <= 1'b0;
                r_line_pix <= 1'b0;
            end else if (w_href_fall) begin
                r_phase    <= 1'b0;
                r_armed    <= 1'b0;
                r_line_pix <= 1'b0;
                if (r_line_pix) begin
                    r_y <= r_y + VW'(1);
                    r_x <= '0;
                end
            end else begin
                if (w_line_start) begin
                    r_armed <= 1'b1;
                end
                if (w_byte) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_hi <= r_data;
                    end else begin
                        r_x        <= r_x + HW'(1);
                        r_line_pix <= 1'b1;
                    end
                end
            end
        end
    end

    assign pix_data     = r_pix_data;
    assign pix_valid    = r_pix_valid;
    assign pix_vsync    = r_pix_vsync;
    assign pix_x        = r_pix_x;
    assign pix_y        = r_pix_y;
    assign frame_ready  = w_active;
    assign odd_line_err = r_odd_err;

endmodule

// File: tb/tb_cam_pixel_pack.sv
// tb/tb_cam_pixel_pack.sv - directed table-driven bench for cam_pixel_pack
module tb_cam_pixel_pack;

    logic        cam_clk;
    logic        cam_rstn;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_vsync;
    logic [2:0]  pix_x;
    logic [11:0] pix_y;
    logic        frame_ready;
    logic        odd_line_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_data;
        logic [2:0]  exp_x;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  x;
        logic [11:0] y;
    } pix_t;

    vec_t tbl[6];
    pix_t q[$];

    cam_pixel_pack #(
        .SKIP_FRAMES (2),
        .HW          (3),
        .VW          (12)
    ) dut (
        .cam_clk      (cam_clk),
        .cam_rstn     (cam_rstn),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_vsync    (pix_vsync),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_ready  (frame_ready),
        .odd_line_err (odd_line_err)
    );

    initial cam_clk = 1'b0;
    always #5 cam_clk = ~cam_clk;

    always @(negedge cam_clk) begin
        if (cam_rstn && pix_valid) begin
            q.push_back('{d: pix_data, x: pix_x, y: pix_y});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_pix(input string nm, input logic [15:0] d, input logic [2:0] x,
                              input logic [11:0] y);
        pix_t p;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: no strobe, expected data=%h x=%0d y=%0d", nm, d, x, y);
        end else begin
            p = q.pop_front();
            if (p.d !== d || p.x !== x || p.y !== y) begin
                errors++;
                $display("FAIL %s: got data=%h x=%0d y=%0d expected data=%h x=%0d y=%0d",
                         nm, p.d, p.x, p.y, d, x, y);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge cam_clk);
        #1;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        cyc(3);
        cam_vsync = 1'b0;
        cyc(3);
    endtask

    // Byte k of the line is seed + k.
    task automatic send_line(input int nbytes, input logic [7:0] seed);
        for (int k = 0; k < nbytes; k++) begin
            cam_href = 1'b1;
            cam_data = 8'(seed + 8'(k));
            cyc(1);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        cyc(4);
    endtask

    task automatic frame(input int lines, input int nbytes);
        vsync_pulse();
        for (int l = 0; l < lines; l++) begin
            send_line(nbytes, 8'(8'h40 + 8'(16 * l)));
        end
    endtask

    task automatic expect_frame(input string nm);
        logic [7:0] s;
        for (int l = 0; l < 2; l++) begin
            s = 8'(8'h40 + 8'(16 * l));
            for (int p = 0; p < 4; p++) begin
                expect_pix(nm, {8'(s + 8'(2 * p)), 8'(s + 8'(2 * p + 1))}, 3'(p), 12'(l));
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_data"},  32'(pix_data),     32'h0);
        chk({nm, "_valid"}, 32'(pix_valid),    32'h0);
        chk({nm, "_vsync"}, 32'(pix_vsync),    32'h0);
        chk({nm, "_x"},     32'(pix_x),        32'h0);
        chk({nm, "_y"},     32'(pix_y),        32'h0);
        chk({nm, "_ready"}, 32'(frame_ready),  32'h0);
        chk({nm, "_err"},   32'(odd_line_err), 32'h0);
    endtask

    initial begin
        tbl[0] = '{hi: 8'hF8, lo: 8'h1F, exp_data: 16'hF81F, exp_x: 3'd0};
        tbl[1] = '{hi: 8'h00, lo: 8'h00, exp_data: 16'h0000, exp_x: 3'd1};
        tbl[2] = '{hi: 8'hFF, lo: 8'hFF, exp_data: 16'hFFFF, exp_x: 3'd2};
        tbl[3] = '{hi: 8'h12, lo: 8'h34, exp_data: 16'h1234, exp_x: 3'd3};
        tbl[4] = '{hi: 8'hA5, lo: 8'h5A, exp_data: 16'hA55A, exp_x: 3'd4};
        tbl[5] = '{hi: 8'h07, lo: 8'hE0, exp_data: 16'h07E0, exp_x: 3'd5};

        cam_rstn  = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        cyc(3);
        chk_all_zero("rst_hold");
        cam_rstn = 1'b1;
        cyc(2);
        chk_all_zero("rst_rel");

        // Start-up skip: two frames discarded, then two good 4x2 frames.
        frame(2, 8);
        frame(2, 8);
        chk("skip_nostrobe", 32'(q.size()), 32'd0);
        chk("skip_notready", 32'(frame_ready), 32'd0);
        frame(2, 8);
        chk("skip_ready", 32'(frame_ready), 32'd1);
        chk("skip_f3_cnt", 32'(q.size()), 32'd8);
        expect_frame("skip_f3");
        frame(2, 8);
        chk("skip_f4_cnt", 32'(q.size()), 32'd8);
        expect_frame("skip_f4");
        chk("skip_noerr", 32'(odd_line_err), 32'd0);

        // Packing order and latency, continuing the line from the table.
        vsync_pulse();
        q.delete();
        cam_href = 1'b1;
        cam_data = tbl[0].hi;
        cyc(1);
        cam_data = tbl[0].lo;
        cyc(1);
        cam_data = tbl[1].hi;
        @(negedge cam_clk);
        chk("pack_lat_early", 32'(pix_valid), 32'd0);
        @(posedge cam_clk); #1;
        cam_data = tbl[1].lo;
        @(negedge cam_clk);
        chk("pack_lat_valid", 32'(pix_valid), 32'd1);
        chk("pack_lat_data", 32'(pix_data), 32'hF81F);
        chk("pack_lat_x", 32'(pix_x), 32'd0);
        @(posedge cam_clk); #1;
        for (int i = 2; i < 6; i++) begin
            cam_data = tbl[i].hi;
            cyc(1);
            cam_data = tbl[i].lo;
            cyc(1);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        cyc(4);
        for (int i = 0; i < 6; i++) begin
            expect_pix($sformatf("pack_tbl%0d", i), tbl[i].exp_data, tbl[i].exp_x, 12'd0);
        end
        chk("pack_extra", 32'(q.size()), 32'd0);

        // Odd byte count: error is sticky and the line still advances pix_y.
        vsync_pulse();
        q.delete();
        send_line(7, 8'h20);
        expect_pix("odd_p0", 16'h2021, 3'd0, 12'd0);
        expect_pix("odd_p1", 16'h2223, 3'd1, 12'd0);
        expect_pix("odd_p2", 16'h2425, 3'd2, 12'd0);
        chk("odd_cnt", 32'(q.size()), 32'd0);
        chk("odd_err_set", 32'(odd_line_err), 32'd1);
        send_line(4, 8'h30);
        expect_pix("odd_next0", 16'h3031, 3'd0, 12'd1);
        expect_pix("odd_next1", 16'h3233, 3'd1, 12'd1);
        frame(2, 8);
        chk("odd_good_cnt", 32'(q.size()), 32'd8);
        chk("odd_err_sticky", 32'(odd_line_err), 32'd1);

        // Column wrap with a 3-bit counter over a 10-pixel line.
        vsync_pulse();
        q.delete();
        send_line(20, 8'h50);
        for (int p = 0; p < 10; p++) begin
            expect_pix($sformatf("wrap_p%0d", p),
                       {8'(8'h50 + 8'(2 * p)), 8'(8'h51 + 8'(2 * p))}, 3'(p % 8), 12'd0);
        end
        chk("wrap_hold_x", 32'(pix_x), 32'd1);
        chk("wrap_hold_data", 32'(pix_data), 32'h6263);

        // Reset mid-line while streaming: outputs clear at once.
        vsync_pulse();
        cam_href = 1'b1;
        cam_data = 8'h11;
        cyc(3);
        cam_rstn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        cyc(2);
        cam_href = 1'b0;
        cam_rstn = 1'b1;
        cyc(2);
        q.delete();
        frame(2, 8);
        chk("rst_skip1_ready", 32'(frame_ready), 32'd0);
        frame(2, 8);
        chk("rst_skip2_ready", 32'(frame_ready), 32'd0);
        chk("rst_skip_nostrobe", 32'(q.size()), 32'd0);

        // Entering ACTIVE with href already high: that line is ignored.
        cam_vsync = 1'b1;
        @(posedge cam_clk);
        @(negedge cam_clk);
        chk("enter_ready_e1", 32'(frame_ready), 32'd0);
        @(posedge cam_clk);
        @(negedge cam_clk);
        chk("enter_ready_e2", 32'(frame_ready), 32'd1);
        chk("enter_pvsync_e2", 32'(pix_vsync), 32'd1);
        @(posedge cam_clk); #1;
        cam_href = 1'b1;
        cam_data = 8'h99;
        cyc(2);
        cam_vsync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cam_data = 8'(8'h60 + 8'(k));
            cyc(1);
        end
        cam_href = 1'b0;
        cyc(4);
        chk("midentry_nostrobe", 32'(q.size()), 32'd0);
        chk("midentry_pvsync", 32'(pix_vsync), 32'd0);
        send_line(4, 8'h70);
        expect_pix("midentry_next0", 16'h7071, 3'd0, 12'd0);
        expect_pix("midentry_next1", 16'h7273, 3'd1, 12'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_pixel_pack.md
# cam_pixel_pack

Camera-domain front end that turns the sensor's 8-bit DVP byte stream into 16-bit RGB565 pixels with qualifiers. It sits directly upstream of the clock-domain-crossing FIFO stage. Its `pix_data` / `pix_valid` / `pix_vsync` drive that stage's data, write-enable and frame-reset inputs. It discards the sensor's unstable start-up frames, tracks pixel/line coordinates, and flags lines with an odd byte count.

## Interface
- `SKIP_FRAMES`, 10: complete frames discarded after the first vsync rising edge; 0 means none.
- `HW`, 12: width of the pixel-column counter.
- `VW`, 12: width of the line counter.

- `cam_clk` in 1: sensor pixel clock; the only clock.
- `cam_rstn` in 1: reset; asynchronous, active-low.
- `cam_vsync` in 1: sensor frame sync; high = vertical blanking.
- `cam_href` in 1: sensor line-valid.
- `cam_data` in 8: sensor byte; high byte of each pixel first.
- `pix_data` out 16: packed pixel `{hi, lo}`.
- `pix_valid` out 1: one-cycle strobe per packed pixel.
- `pix_vsync` out 1: registered vsync; forced 0 outside ACTIVE.
- `pix_x` out HW: column index of the current `pix_data`.
- `pix_y` out VW: line index of the current `pix_data`.
- `frame_ready` out 1: high while in ACTIVE.
- `odd_line_err` out 1: sticky; set when a line ends on an unpaired byte.

## Operation
- **Input stage.** `cam_vsync`, `cam_href` and `cam_data` are registered once. All decisions use the registered copies. Edges are detected against a second delayed copy.
- **FSM states:** IDLE, SKIP, ACTIVE. Reset state is IDLE.
  - IDLE, on vsync rise: go to ACTIVE if `SKIP_FRAMES`==0; otherwise go to SKIP with `skip_cnt`=1.
  - SKIP, on vsync rise: go to ACTIVE if `skip_cnt`==`SKIP_FRAMES`; otherwise `skip_cnt`++.
  - ACTIVE: stays until reset.
- **Line arming.** In ACTIVE, a line is armed only on an href rising edge seen while vsync is low. If href is already high when ACTIVE is entered, that line is ignored. href while vsync is high is ignored.
- **Byte packing in an armed line.** The byte phase toggles each href-high cycle.
  - Phase 0: latch the high byte.
  - Phase 1: register `{hi, lo}` into `pix_data`, pulse `pix_valid`, present `pix_x` = pixels already emitted in this line (first pixel = 0).
- **href falling edge.**
  - Phase is cleared.
  - If phase was 1, the dangling byte is dropped and `odd_line_err` is set.
  - If the line emitted ≥1 pixel, the line counter increments and the column counter clears.
- **vsync rising edge.** Line counter, column counter and phase are cleared. A line in progress is disarmed.
- **Counter wrap.** Column and line counters wrap modulo 2^HW and 2^VW, with no saturation and no flag.
- **Holding.** `pix_data`, `pix_x` and `pix_y` hold their last values when `pix_valid` is low.
- **Clearing `odd_line_err`.** Only reset clears it.

## Timing
- **Reset values.** While `cam_rstn`=0 and after release, every output is 0: `pix_data`, `pix_valid`, `pix_vsync`, `pix_x`, `pix_y`, `frame_ready`, `odd_line_err`. The FSM, `skip_cnt`, counters and phase are also 0/IDLE.
- **Reset mid-frame.** Outputs are immediately 0. After release, the block re-enters IDLE and re-skips `SKIP_FRAMES` frames.
- **Pixel latency.** `pix_valid` is high on the second `cam_clk` rising edge after the low byte is presented on `cam_data`.
- **Sync latency.** `pix_vsync` lags `cam_vsync` by 2 edges, aligned with the pixel path.
- **`frame_ready`.** Rises 2 edges after the vsync rise that enters ACTIVE. `pix_vsync` follows vsync from that same edge.
- **Throughput.** Maximum one `pix_valid` every 2 cycles. There is no back-pressure; the downstream stage must accept every strobe.
- **Simultaneous events.**
  - If href falls on the same registered cycle as a vsync rise, the vsync clear wins: counters end at 0, and `odd_line_err` is still evaluated.
  - A phase-1 byte coincident with the href fall is not possible, because href is low on that byte.

## Structure
- Shared package `cam_pkg`: typedef `cam_pack_state_e` {IDLE, SKIP, ACTIVE}, and constant `CAM_BYTE_W` = 8.
- One natural sub-module, `cam_edge_det`: registered rise/fall detector, instantiated for vsync and href.

## Test plan
- **Skip count.** `SKIP_FRAMES`=2 with four 4×2-pixel frames. No `pix_valid` until the 3rd vsync rise. Frames 3–4 each yield 8 strobes, with (x, y) running (0,0)…(3,1).
- **Packing order.** Bytes 0xF8, 0x1F in an armed line. `pix_data`=0xF81F, `pix_valid` pulses on the 2nd edge after 0x1F, `pix_x`=0.
- **Odd line.** 7 bytes in one line. 3 strobes occur, `odd_line_err` becomes 1 and stays 1 through the next good frame, and the next line has `pix_y`=1.
- **Mid-line entry.** href already high when ACTIVE is entered. No strobes for that line; the next line starts at `pix_x`=0, `pix_y`=0.
- **Wrap.** `HW`=3 with a 10-pixel line. `pix_x` runs 0..7, 0, 1.
- **Reset mid-frame.** Assert `cam_rstn`=0 mid-frame in ACTIVE. All outputs are 0 immediately, and `frame_ready` returns only after `SKIP_FRAMES` further frames.
